adc_data_output: RTL

//  Frame serializer: the ADC-facing transmit end of the 4-lane nDRDY/DOUT data interface.

---
 rtl/adc_data_output.sv | 98 +++++++++
 1 files changed

// File: rtl/adc_data_output.sv
// adc_data_output: 4-lane nDRDY/DOUT frame serializer fed through a one-deep holding register
// Ports: MCLK clock (rising edge); nRST async active-low reset; nSYNC_IN sync active-low abort/resync;
//   DIN_VALID/DIN_READY/DIN frame handshake, DIN[k] leaves on DOUT[k] MSB-first;
//   nDRDY one-cycle frame strobe; DOUT serial lanes; BUSY while shifting; UNDERRUN empty-slot pulse.
// Option: define ADC_TX_REPEAT_EN to resend the last transmitted frame on slots with an empty hold.
module adc_data_output #(
  parameter int WORD_W       = 64,
  parameter int LANES        = 4,
  parameter int FRAME_PERIOD = 128
) (
  input  logic                         MCLK,
  input  logic                         nRST,
  input  logic                         nSYNC_IN,
  input  logic                         DIN_VALID,
  output logic                         DIN_READY,
  input  logic [LANES-1:0][WORD_W-1:0] DIN,
  output logic                         nDRDY,
  output logic [LANES-1:0]             DOUT,
  output logic                         BUSY,
  output logic                         UNDERRUN
);
  localparam int PW = $clog2(FRAME_PERIOD);
  localparam int BW = $clog2(WORD_W);
  if (FRAME_PERIOD < WORD_W + 2) begin : g_bad_period
    $error("FRAME_PERIOD must be >= WORD_W+2");
  end
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [PW-1:0] pcnt;
  logic [BW-1:0] bcnt;
  logic [LANES-1:0][WORD_W-1:0] hold, shreg, src, sh_src;
  logic hold_full, slot, idle_slot, load, run, underrun_n;
`ifdef ADC_TX_REPEAT_EN
  logic [LANES-1:0][WORD_W-1:0] last;
  logic have_last;
`endif
  assign DIN_READY = ~hold_full;
  assign slot = pcnt == PW'(FRAME_PERIOD - 1);
  assign idle_slot = nSYNC_IN && state == IDLE && slot;
  assign run = state_n == SHIFT;
  // the bit driven next cycle comes from the freshly loaded frame or the running shift register
  assign sh_src = load ? src : shreg;
  always_comb begin
    underrun_n = idle_slot && !hold_full;
`ifdef ADC_TX_REPEAT_EN
    load = idle_slot && (hold_full || have_last);
    src = hold_full ? hold : last;
`else
    load = idle_slot && hold_full;
    src = hold;
`endif
    state_n = !nSYNC_IN ? IDLE :
              load ? SHIFT :
              (state == SHIFT && bcnt == BW'(WORD_W - 1)) ? IDLE : state;
  end
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      pcnt <= '0;
      bcnt <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      shreg <= '0;
      nDRDY <= 1'b1;
      DOUT <= '0;
      BUSY <= 1'b0;
      UNDERRUN <= 1'b0;
    end else begin
      pcnt <= (!nSYNC_IN || slot) ? '0 : pcnt + PW'(1);
      bcnt <= (run && !load) ? bcnt + BW'(1) : '0;
      UNDERRUN <= underrun_n;
      nDRDY <= ~load;
      BUSY <= run;
      if (DIN_VALID && !hold_full) begin
        hold <= DIN;
        hold_full <= 1'b1;
      end else if (load) hold_full <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        DOUT[k] <= run & sh_src[k][WORD_W-1];
        if (run) shreg[k] <= {sh_src[k][WORD_W-2:0], 1'b0};
      end
    end
  end
`ifdef ADC_TX_REPEAT_EN
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      last <= '0;
      have_last <= 1'b0;
    end else if (load) begin
      last <= src;
      have_last <= 1'b1;
    end
  end
`endif
endmodule
